nerv_mem_arbiter: RTL and testbench
===================================

NERV_MEM_ARBITER -- requirements
Module: nerv_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max wait cycles per memory transfer before forced fault (8-bit counter).
REQ-002 clock  in  1  sole clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 stall  out  1  core stall; core advances only in cycles with stall=0.
REQ-005 imem_addr  in  32  core fetch address.
REQ-006 imem_data  out  32  fetched instruction.
REQ-007 imem_fault  out  1  fetch fault.
REQ-008 dmem_valid  in  1  core data request.
REQ-009 dmem_addr  in  32  data address.
REQ-010 dmem_wstrb  in  4  byte write strobes; 0 = load.
REQ-011 dmem_wdata  in  32  store data.
REQ-012 dmem_rdata  out  32  load data.
REQ-013 dmem_fault  out  1  data fault.
REQ-014 mem_req  out  1  shared single-port request.
REQ-015 mem_addr  out  32  shared port address.
REQ-016 mem_we  out  4  shared port byte write enables.
REQ-017 mem_wdata  out  32  shared port write data.
REQ-018 mem_rdata  in  32  shared port read data, valid with mem_ready.
REQ-019 mem_ready  in  1  transfer completes in a cycle with mem_req=1 and mem_ready=1 (same-cycle ready allowed).
REQ-020 mem_fault  in  1  error qualifier, sampled with mem_ready.

Function
REQ-021 States: BOOT, DATA, INSN, RESP; 2-bit encoding free.
REQ-022 stall=1 in BOOT, DATA, INSN; stall=0 only in RESP.
REQ-023 BOOT: latch imem_addr into fetch register, ignore dmem_*, next state INSN.
REQ-024 RESP: latch imem_addr, dmem_valid, dmem_addr, dmem_wstrb, dmem_wdata; next DATA if dmem_valid else INSN.
REQ-025 DATA: mem_req=1, mem_addr=latched dmem_addr, mem_we=latched wstrb, mem_wdata=latched wdata; on transfer go INSN.
REQ-026 DATA load (wstrb=0) transfer: dmem_rdata<=mem_rdata, dmem_fault<=mem_fault; store transfer: dmem_rdata unchanged, dmem_fault<=mem_fault.
REQ-027 INSN: mem_req=1, mem_addr=latched fetch address, mem_we=0; on transfer imem_data<=mem_rdata, imem_fault<=mem_fault, go RESP.
REQ-028 mem_req=0, mem_we=0 in BOOT and RESP; mem_addr/mem_wdata don't-care there.
REQ-029 While mem_req=1 and no transfer, mem_addr, mem_we, mem_wdata SHALL hold stable.
REQ-030 Data access always precedes fetch of the same core step; core-visible latency = 2 + memory wait cycles (no dmem) or 3 + waits (with dmem).
REQ-031 Wait counter clears on entering DATA/INSN, increments each non-transfer cycle in DATA/INSN.
REQ-032 Counter reaching TIMEOUT without transfer: abort access, set that channel's fault=1, data output for loads/fetch = 0, advance as on transfer.
REQ-033 dmem_fault clears to 0 on each RESP capture with dmem_valid=0; imem_fault updates on each INSN completion.
REQ-034 Outputs imem_data, dmem_rdata, faults stable throughout RESP and all stall cycles until next update.
REQ-035 mem_fault ignored when mem_ready=0.

Reset
REQ-036 reset_n=0 asynchronously forces BOOT, stall=1, mem_req=0, mem_we=0, counter=0, imem_data=0, dmem_rdata=0, imem_fault=0, dmem_fault=0, latched registers=0.
REQ-037 Reset mid-transfer abandons the access immediately; no output updates from the aborted transfer.
REQ-038 First cycle after reset_n rises is BOOT.

Verification
REQ-039 Reset release, imem_addr=0x0000_0000, mem_ready=1 always, mem_rdata=0x0000_0013 -> BOOT, INSN, RESP; stall=0 on 3rd cycle with imem_data=0x13.
REQ-040 RESP with dmem_valid=1, wstrb=0, dmem_addr=0x100, imem_addr=0x4; memory returns 0xDEAD_BEEF then 0x0000_0093 -> mem_addr 0x100 then 0x4; dmem_rdata=0xDEADBEEF, imem_data=0x93, stall high exactly 2 cycles.
REQ-041 Store wstrb=0x3, wdata=0x1234_5678, addr=0x200 -> mem_we=0x3, mem_wdata=0x12345678 held until ready; dmem_rdata unchanged.
REQ-042 mem_ready held low with TIMEOUT=4 in INSN -> exactly 4 wait cycles, then imem_fault=1, imem_data=0, RESP.
REQ-043 mem_ready delayed 3 cycles in DATA -> mem_addr/mem_we/mem_wdata constant over all 4 cycles; mem_fault=1 on transfer -> dmem_fault=1.
REQ-044 reset_n low during DATA wait -> same cycle mem_req=0, stall=1; after release BOOT refetch, prior outputs zeroed.

Source files
------------

// File: rtl/nerv_mem_arbiter.sv
// Shares one single-port memory between the NERV core's fetch and data channels,
// stalling the core while the data access (if any) and then the next fetch complete.
module nerv_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        stall,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        imem_fault,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        mem_fault
);

  typedef enum logic [1:0] {BOOT, DATA, INSN, RESP} state_e;

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [31:0] fetchAddr_q, fetchAddr_d;
  logic [31:0] dAddr_q, dAddr_d;
  logic [3:0]  dWstrb_q, dWstrb_d;
  logic [31:0] dWdata_q, dWdata_d;
  logic [31:0] imemData_q, imemData_d;
  logic        imemFault_q, imemFault_d;
  logic [31:0] dmemRdata_q, dmemRdata_d;
  logic        dmemFault_q, dmemFault_d;
  logic [8:0]  waitNext;
  logic        timeout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BOOT;
      waitCnt_q   <= '0;
      fetchAddr_q <= '0;
      dAddr_q     <= '0;
      dWstrb_q    <= '0;
      dWdata_q    <= '0;
      imemData_q  <= '0;
      imemFault_q <= 1'b0;
      dmemRdata_q <= '0;
      dmemFault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      fetchAddr_q <= fetchAddr_d;
      dAddr_q     <= dAddr_d;
      dWstrb_q    <= dWstrb_d;
      dWdata_q    <= dWdata_d;
      imemData_q  <= imemData_d;
      imemFault_q <= imemFault_d;
      dmemRdata_q <= dmemRdata_d;
      dmemFault_q <= dmemFault_d;
    end
  end

  // A wait cycle that would bring the counter to TIMEOUT aborts the access instead.
  assign waitNext = {1'b0, waitCnt_q} + 9'd1;
  assign timeout  = !mem_ready && (waitNext >= TimeoutLim);

  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    fetchAddr_d = fetchAddr_q;
    dAddr_d     = dAddr_q;
    dWstrb_d    = dWstrb_q;
    dWdata_d    = dWdata_q;
    imemData_d  = imemData_q;
    imemFault_d = imemFault_q;
    dmemRdata_d = dmemRdata_q;
    dmemFault_d = dmemFault_q;
    stall       = 1'b1;
    mem_req     = 1'b0;
    mem_addr    = fetchAddr_q;
    mem_we      = 4'h0;
    mem_wdata   = dWdata_q;

    case (state_q)
      BOOT: begin
        fetchAddr_d = imem_addr;
        waitCnt_d   = '0;
        state_d     = INSN;
      end
      RESP: begin
        stall       = 1'b0;
        fetchAddr_d = imem_addr;
        dAddr_d     = dmem_addr;
        dWstrb_d    = dmem_wstrb;
        dWdata_d    = dmem_wdata;
        waitCnt_d   = '0;
        if (dmem_valid) begin
          state_d = DATA;
        end else begin
          dmemFault_d = 1'b0;
          state_d     = INSN;
        end
      end
      DATA: begin
        mem_req  = 1'b1;
        mem_addr = dAddr_q;
        mem_we   = dWstrb_q;
        if (mem_ready) begin
          if (dWstrb_q == 4'h0) dmemRdata_d = mem_rdata;
          dmemFault_d = mem_fault;
          waitCnt_d   = '0;
          state_d     = INSN;
        end else if (timeout) begin
          if (dWstrb_q == 4'h0) dmemRdata_d = '0;
          dmemFault_d = 1'b1;
          waitCnt_d   = '0;
          state_d     = INSN;
        end else begin
          waitCnt_d = waitNext[7:0];
        end
      end
      INSN: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          imemData_d  = mem_rdata;
          imemFault_d = mem_fault;
          waitCnt_d   = '0;
          state_d     = RESP;
        end else if (timeout) begin
          imemData_d  = '0;
          imemFault_d = 1'b1;
          waitCnt_d   = '0;
          state_d     = RESP;
        end else begin
          waitCnt_d = waitNext[7:0];
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign imem_data  = imemData_q;
  assign imem_fault = imemFault_q;
  assign dmem_rdata = dmemRdata_q;
  assign dmem_fault = dmemFault_q;

endmodule

// File: tb/tb_nerv_mem_arbiter.sv
// Testbench for nerv_mem_arbiter: acts as both the core and the shared memory, and
// compares bus activity and core-visible results against a step-level model.
module tb_nerv_mem_arbiter;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_data;
  logic        imem_fault;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_wstrb = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_fault;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_fault = 1'b0;

  nerv_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_fault(imem_fault),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_fault(dmem_fault),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_fault(mem_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        chkW;
  } busT;

  typedef struct {
    logic        dv;
    logic [31:0] da;
    logic [3:0]  dw;
    logic [31:0] dd;
    logic [31:0] ia;
    int          waitD;
    int          waitI;
    logic        fD;
    logic        fI;
    logic [31:0] rD;
    logic [31:0] rI;
  } stepT;

  busT obs[$];
  busT expq[$];

  logic [31:0] mImem = '0;
  logic [31:0] mDrd = '0;
  logic        mIf = 1'b0;
  logic        mDf = 1'b0;

  int total = 0;
  int bad = 0;

  function automatic stepT mkStep(input logic dv, input logic [31:0] da, input logic [3:0] dw,
                                  input logic [31:0] dd, input logic [31:0] ia,
                                  input int waitD, input int waitI, input logic fD,
                                  input logic fI, input logic [31:0] rD, input logic [31:0] rI);
    stepT s;
    s.dv = dv; s.da = da; s.dw = dw; s.dd = dd; s.ia = ia;
    s.waitD = waitD; s.waitI = waitI; s.fD = fD; s.fI = fI; s.rD = rD; s.rI = rI;
    return s;
  endfunction

  function automatic logic [31:0] obsAddr(input int i);
    if (i < obs.size()) return obs[i].addr;
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [3:0] obsWe(input int i);
    if (i < obs.size()) return obs[i].we;
    return 4'hx;
  endfunction

  function automatic logic [31:0] obsWd(input int i);
    if (i < obs.size()) return obs[i].wdata;
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic obsReq(input int i);
    if (i < obs.size()) return obs[i].req;
    return 1'bx;
  endfunction

  // Plays one core step starting from a RESP cycle: presents the request, then serves
  // memory with the planned wait counts and records the bus during every stall cycle.
  task automatic applyStimulus(input stepT s);
    int phase;
    int k;
    int waits;
    int guard;
    imem_addr  = s.ia;
    dmem_valid = s.dv;
    dmem_addr  = s.da;
    dmem_wstrb = s.dw;
    dmem_wdata = s.dd;
    mem_ready  = 1'b0;
    mem_rdata  = $urandom;
    mem_fault  = 1'($urandom);
    @(posedge clock);
    @(negedge clock);
    obs.delete();
    phase = s.dv ? 0 : 1;
    k = 0;
    guard = 0;
    while (stall === 1'b1 && guard < 64) begin
      obs.push_back('{req: mem_req, addr: mem_addr, we: mem_we, wdata: mem_wdata, chkW: 1'b0});
      waits = (phase == 0) ? s.waitD : (phase == 1) ? s.waitI : -1;
      if (k == waits) begin
        mem_ready = 1'b1;
        mem_rdata = (phase == 0) ? s.rD : s.rI;
        mem_fault = (phase == 0) ? s.fD : s.fI;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        mem_fault = 1'($urandom);
      end
      imem_addr  = $urandom;
      dmem_valid = 1'($urandom);
      dmem_addr  = $urandom;
      dmem_wstrb = 4'($urandom);
      dmem_wdata = $urandom;
      if (k == waits || k + 1 >= TMO) begin
        phase++;
        k = 0;
      end else begin
        k++;
      end
      @(posedge clock);
      @(negedge clock);
      guard++;
    end
    mem_ready = 1'b0;
  endtask

  // Step-level model: each channel either completes after its wait count or is cut off
  // after TMO cycles with a fault; results follow from that outcome alone.
  task automatic expectStep(input stepT s);
    int n;
    expq.delete();
    if (s.dv) begin
      n = (s.waitD + 1 < TMO) ? s.waitD + 1 : TMO;
      for (int i = 0; i < n; i++)
        expq.push_back('{req: 1'b1, addr: s.da, we: s.dw, wdata: s.dd, chkW: 1'b1});
      if (s.waitD < TMO) begin
        if (s.dw == 4'h0) mDrd = s.rD;
        mDf = s.fD;
      end else begin
        if (s.dw == 4'h0) mDrd = '0;
        mDf = 1'b1;
      end
    end else begin
      mDf = 1'b0;
    end
    n = (s.waitI + 1 < TMO) ? s.waitI + 1 : TMO;
    for (int i = 0; i < n; i++)
      expq.push_back('{req: 1'b1, addr: s.ia, we: 4'h0, wdata: 32'h0, chkW: 1'b0});
    if (s.waitI < TMO) begin
      mImem = s.rI;
      mIf   = s.fI;
    end else begin
      mImem = '0;
      mIf   = 1'b1;
    end
  endtask

  // Outputs held in reset must show the cleared arbiter.
  task automatic test_reset;
    @(negedge clock);
    @(negedge clock);
    total++;
    if ({stall, mem_req, mem_we} !== {1'b1, 1'b0, 4'h0}) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got stall=%b req=%b we=%h want 1 0 0", stall, mem_req, mem_we);
    end
    total++;
    if ({imem_data, imem_fault, dmem_rdata, dmem_fault} !== 66'h0) begin
      bad++;
      $display("[TB] FAIL reset_outs: got imem=%h if=%b drd=%h df=%b want zeros",
               imem_data, imem_fault, dmem_rdata, dmem_fault);
    end
  endtask

  // First fetch after reset: BOOT, INSN, then RESP with the fetched word.
  task automatic test_boot;
    reset_n    = 1'b1;
    imem_addr  = 32'h0;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h0000_0013;
    mem_fault  = 1'b0;
    dmem_valid = 1'b1;
    total++;
    if ({stall, mem_req} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL boot_cycle: got stall=%b req=%b want 1 0", stall, mem_req);
    end
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({stall, mem_req, mem_addr, mem_we} !== {1'b1, 1'b1, 32'h0, 4'h0}) begin
      bad++;
      $display("[TB] FAIL boot_insn: got stall=%b req=%b addr=%h we=%h want 1 1 0 0",
               stall, mem_req, mem_addr, mem_we);
    end
    @(posedge clock);
    @(negedge clock);
    mem_ready = 1'b0;
    total++;
    if ({stall, imem_data, imem_fault} !== {1'b0, 32'h13, 1'b0}) begin
      bad++;
      $display("[TB] FAIL boot_resp: got stall=%b imem=%h if=%b want 0 00000013 0",
               stall, imem_data, imem_fault);
    end
    mImem = 32'h13; mIf = 1'b0; mDrd = '0; mDf = 1'b0;
  endtask

  // Load then fetch, both completing immediately.
  task automatic test_load;
    stepT s;
    s = mkStep(1'b1, 32'h100, 4'h0, 32'h0, 32'h4, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h93);
    applyStimulus(s);
    expectStep(s);
    total++;
    if (obs.size() != 2) begin
      bad++;
      $display("[TB] FAIL load_stall_len: got %0d want 2", obs.size());
    end
    total++;
    if (obsAddr(0) !== 32'h100 || obsAddr(1) !== 32'h4) begin
      bad++;
      $display("[TB] FAIL load_addr_seq: got %h,%h want 00000100,00000004", obsAddr(0), obsAddr(1));
    end
    total++;
    if ({stall, dmem_rdata, imem_data, dmem_fault} !== {1'b0, 32'hDEAD_BEEF, 32'h93, 1'b0}) begin
      bad++;
      $display("[TB] FAIL load_result: got stall=%b drd=%h imem=%h df=%b want 0 deadbeef 00000093 0",
               stall, dmem_rdata, imem_data, dmem_fault);
    end
  endtask

  // Store held for two wait cycles; load data must not change.
  task automatic test_store;
    stepT s;
    s = mkStep(1'b1, 32'h200, 4'h3, 32'h1234_5678, 32'h8, 2, 0, 1'b0, 1'b0, 32'hAAAA_5555, 32'h13);
    applyStimulus(s);
    expectStep(s);
    total++;
    if (obs.size() != 4) begin
      bad++;
      $display("[TB] FAIL store_stall_len: got %0d want 4", obs.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obsAddr(i) !== 32'h200 || obsWe(i) !== 4'h3 || obsWd(i) !== 32'h1234_5678) begin
        bad++;
        $display("[TB] FAIL store_bus%0d: got addr=%h we=%h wd=%h want 00000200 3 12345678",
                 i, obsAddr(i), obsWe(i), obsWd(i));
      end
    end
    total++;
    if (obsAddr(3) !== 32'h8 || obsWe(3) !== 4'h0) begin
      bad++;
      $display("[TB] FAIL store_fetch: got addr=%h we=%h want 00000008 0", obsAddr(3), obsWe(3));
    end
    total++;
    if ({dmem_rdata, dmem_fault} !== {32'hDEAD_BEEF, 1'b0}) begin
      bad++;
      $display("[TB] FAIL store_rdata_kept: got drd=%h df=%b want deadbeef 0", dmem_rdata, dmem_fault);
    end
  endtask

  // Fetch never acknowledged: cut off after TMO cycles with a fault and zero data.
  task automatic test_timeout;
    stepT s;
    s = mkStep(1'b0, 32'h0, 4'h0, 32'h0, 32'hC, 0, 100, 1'b0, 1'b0, 32'h0, 32'h1234);
    applyStimulus(s);
    expectStep(s);
    total++;
    if (obs.size() != TMO) begin
      bad++;
      $display("[TB] FAIL timeout_len: got %0d want %0d", obs.size(), TMO);
    end
    total++;
    if ({stall, imem_data, imem_fault, dmem_fault} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL timeout_result: got stall=%b imem=%h if=%b df=%b want 0 00000000 1 0",
               stall, imem_data, imem_fault, dmem_fault);
    end
  endtask

  // Store acknowledged after three waits with an error flag; bus held constant meanwhile.
  task automatic test_wait_fault;
    stepT s;
    s = mkStep(1'b1, 32'h300, 4'hF, 32'hCAFE_F00D, 32'h10, 3, 0, 1'b1, 1'b0, 32'h0, 32'h33);
    applyStimulus(s);
    expectStep(s);
    total++;
    if (obs.size() != 5) begin
      bad++;
      $display("[TB] FAIL wfault_len: got %0d want 5", obs.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obsAddr(i) !== 32'h300 || obsWe(i) !== 4'hF || obsWd(i) !== 32'hCAFE_F00D) begin
        bad++;
        $display("[TB] FAIL wfault_bus%0d: got addr=%h we=%h wd=%h want 00000300 f cafef00d",
                 i, obsAddr(i), obsWe(i), obsWd(i));
      end
    end
    total++;
    if ({dmem_fault, dmem_rdata, imem_data, imem_fault} !== {1'b1, 32'hDEAD_BEEF, 32'h33, 1'b0}) begin
      bad++;
      $display("[TB] FAIL wfault_result: got df=%b drd=%h imem=%h if=%b want 1 deadbeef 00000033 0",
               dmem_fault, dmem_rdata, imem_data, imem_fault);
    end
  endtask

  // Random core steps and memory timing against the step-level model.
  task automatic test_random;
    stepT s;
    for (int n = 0; n < 40; n++) begin
      s = mkStep(1'($urandom), $urandom,
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                 $urandom, $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                 1'($urandom), 1'($urandom), $urandom, $urandom);
      applyStimulus(s);
      expectStep(s);
      total++;
      if (obs.size() != expq.size()) begin
        bad++;
        $display("[TB] FAIL rnd%0d_len: got %0d want %0d", n, obs.size(), expq.size());
      end
      for (int i = 0; i < expq.size(); i++) begin
        total++;
        if (obsReq(i) !== 1'b1 || obsAddr(i) !== expq[i].addr || obsWe(i) !== expq[i].we ||
            (expq[i].chkW && obsWd(i) !== expq[i].wdata)) begin
          bad++;
          $display("[TB] FAIL rnd%0d_bus%0d: got req=%b addr=%h we=%h wd=%h want 1 %h %h %h",
                   n, i, obsReq(i), obsAddr(i), obsWe(i), obsWd(i),
                   expq[i].addr, expq[i].we, expq[i].wdata);
        end
      end
      total++;
      if ({stall, imem_data, imem_fault, dmem_rdata, dmem_fault} !== {1'b0, mImem, mIf, mDrd, mDf}) begin
        bad++;
        $display("[TB] FAIL rnd%0d_out: got stall=%b imem=%h if=%b drd=%h df=%b want 0 %h %b %h %b",
                 n, stall, imem_data, imem_fault, dmem_rdata, dmem_fault, mImem, mIf, mDrd, mDf);
      end
    end
  endtask

  // Reset asserted while a load waits: bus drops at once and outputs clear.
  task automatic test_reset_mid;
    stepT s;
    s = mkStep(1'b1, 32'h500, 4'h0, 32'h0, 32'h24, 0, 0, 1'b0, 1'b0, 32'h5555_AAAA, 32'h77);
    applyStimulus(s);
    expectStep(s);
    total++;
    if ({dmem_rdata, imem_data} !== {32'h5555_AAAA, 32'h77}) begin
      bad++;
      $display("[TB] FAIL rmid_setup: got drd=%h imem=%h want 5555aaaa 00000077", dmem_rdata, imem_data);
    end
    imem_addr  = 32'h28;
    dmem_valid = 1'b1;
    dmem_addr  = 32'h400;
    dmem_wstrb = 4'h0;
    mem_ready  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h400}) begin
      bad++;
      $display("[TB] FAIL rmid_data: got req=%b addr=%h want 1 00000400", mem_req, mem_addr);
    end
    @(posedge clock);
    @(negedge clock);
    #2;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    mem_fault = 1'b1;
    #1;
    total++;
    if ({mem_req, stall, mem_we} !== {1'b0, 1'b1, 4'h0}) begin
      bad++;
      $display("[TB] FAIL rmid_async: got req=%b stall=%b we=%h want 0 1 0", mem_req, stall, mem_we);
    end
    @(negedge clock);
    mem_ready = 1'b0;
    total++;
    if ({imem_data, imem_fault, dmem_rdata, dmem_fault} !== 66'h0) begin
      bad++;
      $display("[TB] FAIL rmid_zero: got imem=%h if=%b drd=%h df=%b want zeros",
               imem_data, imem_fault, dmem_rdata, dmem_fault);
    end
    reset_n   = 1'b1;
    imem_addr = 32'h20;
    total++;
    if ({stall, mem_req} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL rmid_boot: got stall=%b req=%b want 1 0", stall, mem_req);
    end
    @(posedge clock);
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'h99;
    mem_fault = 1'b0;
    total++;
    if ({mem_req, mem_addr, mem_we} !== {1'b1, 32'h20, 4'h0}) begin
      bad++;
      $display("[TB] FAIL rmid_refetch: got req=%b addr=%h we=%h want 1 00000020 0",
               mem_req, mem_addr, mem_we);
    end
    @(posedge clock);
    @(negedge clock);
    mem_ready = 1'b0;
    total++;
    if ({stall, imem_data, dmem_rdata, dmem_fault} !== {1'b0, 32'h99, 32'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rmid_resp: got stall=%b imem=%h drd=%h df=%b want 0 00000099 00000000 0",
               stall, imem_data, dmem_rdata, dmem_fault);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_load();
    test_store();
    test_timeout();
    test_wait_fault();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
